interrupt_service_responder: RTL and testbench

CPU-side responder for the priority-encoded interrupt controller. It samples the controller's irq/ack pair and decodes the one-hot ack into a source index. It then runs a service window of programmable length and returns a one-cycle done pulse to the controller. It also queues one interrupt that arrives during service, flags protocol errors, and optionally keeps per-source service counts.

---
 rtl/interrupt_service_responder.sv | 139 +++++++++++++
 tb/tb_interrupt_service_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/interrupt_service_responder.sv
// CPU-side responder: decodes irq/ack, runs a timed service window, pulses done.
// Optional `SVC_COUNT_EN adds per-source saturating completed-service counters.
module interrupt_service_responder #(
    parameter int No_IP   = 4,
    parameter int bit_req = $clog2(No_IP),
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   irq,
    input  logic [No_IP-1:0]       ack,
    input  logic [7:0]             svc_len,
    output logic                   done,
    output logic                   svc_active,
    output logic [bit_req-1:0]     svc_id,
    output logic                   pend_valid,
    output logic                   ovf_err,
    output logic                   ack_err,
    output logic [No_IP*CNT_W-1:0] svc_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        SERVICE = 3'b010,
        DONE    = 3'b100
    } state_t;

    state_t             state, state_n;
    logic [7:0]         cnt;
    logic [7:0]         len_m1;
    logic [bit_req-1:0] pend_id;
    logic [bit_req-1:0] cap_idx;
    logic [bit_req-1:0] start_id;
    logic               cap_ok, cap_bad;
    logic               start;
    logic               pend_load, pend_drop;

    assign cap_ok  = irq & $onehot(ack);
    assign cap_bad = irq & ~$onehot(ack);
    assign len_m1  = (svc_len == 8'd0) ? 8'd0 : svc_len - 8'd1;

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < No_IP; i++) begin
            if (ack[i]) cap_idx = bit_req'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // A queued request always wins over a fresh one when leaving DONE
    always_comb begin
        state_n  = state;
        start    = 1'b0;
        start_id = cap_idx;
        unique case (state)
            IDLE: begin
                if (cap_ok) begin
                    state_n = SERVICE;
                    start   = 1'b1;
                end
            end
            SERVICE: begin
                if (cnt == 8'd0) state_n = DONE;
            end
            DONE: begin
                if (pend_valid) begin
                    state_n  = SERVICE;
                    start    = 1'b1;
                    start_id = pend_id;
                end else if (cap_ok) begin
                    state_n = SERVICE;
                    start   = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        done       = (state == DONE);
        svc_active = (state == SERVICE);
    end

    assign pend_load = cap_ok & (((state == SERVICE) & ~pend_valid) |
                                 ((state == DONE) & pend_valid));
    assign pend_drop = cap_ok & (state == SERVICE) & pend_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 8'd0;
            svc_id     <= '0;
            pend_valid <= 1'b0;
            pend_id    <= '0;
            ovf_err    <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            if (start) begin
                cnt    <= len_m1;
                svc_id <= start_id;
            end else if (state == SERVICE && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            // Refill in DONE overrides the consume of the old entry
            if (pend_load) begin
                pend_valid <= 1'b1;
                pend_id    <= cap_idx;
            end else if (state == DONE && pend_valid) begin
                pend_valid <= 1'b0;
            end
            if (pend_drop) ovf_err <= 1'b1;
            if (cap_bad)   ack_err <= 1'b1;
        end
    end

`ifdef SVC_COUNT_EN
    logic [CNT_W-1:0] cnt_q [No_IP];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < No_IP; i++) cnt_q[i] <= '0;
        end else if (state == DONE && ~&cnt_q[svc_id]) begin
            cnt_q[svc_id] <= cnt_q[svc_id] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < No_IP; g++) begin : g_cnt
        assign svc_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    assign svc_cnt = '0;
`endif

endmodule

// File: tb/tb_interrupt_service_responder.sv
// Directed self-checking bench for interrupt_service_responder.
// Counter expectations follow whether SVC_COUNT_EN is defined.
module tb_interrupt_service_responder;

    localparam int NIP = 4;
    localparam int CW  = 2;
`ifdef SVC_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           irq;
    logic [NIP-1:0] ack;
    logic [7:0]     svc_len;
    logic           done;
    logic           svc_active;
    logic [1:0]     svc_id;
    logic           pend_valid;
    logic           ovf_err;
    logic           ack_err;
    logic [NIP*CW-1:0] svc_cnt;

    int checks = 0;
    int errors = 0;

    interrupt_service_responder #(
        .No_IP(NIP),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .irq(irq),
        .ack(ack),
        .svc_len(svc_len),
        .done(done),
        .svc_active(svc_active),
        .svc_id(svc_id),
        .pend_valid(pend_valid),
        .ovf_err(ovf_err),
        .ack_err(ack_err),
        .svc_cnt(svc_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic a, input logic d,
                          input logic [1:0] id);
        chk({tag, "_active"}, 32'(svc_active), 32'(a));
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_id"}, 32'(svc_id), 32'(id));
    endtask

    initial begin
        reset   = 1'b1;
        irq     = 1'b0;
        ack     = '0;
        svc_len = 8'd0;
        tick();
        tick();
        chk_st("rst", 1'b0, 1'b0, 2'd0);
        chk("rst_pend", 32'(pend_valid), 32'(0));
        chk("rst_ovf", 32'(ovf_err), 32'(0));
        chk("rst_ackerr", 32'(ack_err), 32'(0));
        chk("rst_cnt", 32'(svc_cnt), 32'(0));

        // Basic service, len 3, source 2
        reset = 1'b0;
        irq = 1'b1; ack = 4'b0100; svc_len = 8'd3;
        tick();
        irq = 1'b0; ack = '0;
        chk_st("b1", 1'b1, 1'b0, 2'd2);
        tick(); chk_st("b2", 1'b1, 1'b0, 2'd2);
        tick(); chk_st("b3", 1'b1, 1'b0, 2'd2);
        tick(); chk_st("b4", 1'b0, 1'b1, 2'd2);
        tick(); chk_st("b5", 1'b0, 1'b0, 2'd2);
        chk("b_cnt", 32'(svc_cnt), CNT_ON ? 32'h10 : 32'h0);

        // Zero length treated as one cycle
        irq = 1'b1; ack = 4'b0001; svc_len = 8'd0;
        tick();
        irq = 1'b0; ack = '0;
        chk_st("z1", 1'b1, 1'b0, 2'd0);
        tick(); chk_st("z2", 1'b0, 1'b1, 2'd0);
        tick(); chk_st("z3", 1'b0, 1'b0, 2'd0);

        // Pending queue, back-to-back without IDLE gap
        irq = 1'b1; ack = 4'b0010; svc_len = 8'd4;
        tick();
        chk_st("p1", 1'b1, 1'b0, 2'd1);
        ack = 4'b1000; svc_len = 8'd2;
        tick();
        irq = 1'b0; ack = '0;
        chk("p2_pend", 32'(pend_valid), 32'(1));
        chk_st("p2", 1'b1, 1'b0, 2'd1);
        tick(); chk_st("p3", 1'b1, 1'b0, 2'd1);
        tick(); chk_st("p4", 1'b1, 1'b0, 2'd1);
        tick(); chk_st("p5", 1'b0, 1'b1, 2'd1);
        tick(); chk_st("p6", 1'b1, 1'b0, 2'd3);
        chk("p6_pend", 32'(pend_valid), 32'(0));
        tick(); chk_st("p7", 1'b1, 1'b0, 2'd3);
        tick(); chk_st("p8", 1'b0, 1'b1, 2'd3);
        tick(); chk_st("p9", 1'b0, 1'b0, 2'd3);

        // Overflow keeps the older pending id; bad ack only flags
        irq = 1'b1; ack = 4'b0001; svc_len = 8'd5;
        tick();
        ack = 4'b0010;
        tick();
        ack = 4'b0100;
        tick();
        chk("o_pend", 32'(pend_valid), 32'(1));
        chk("o_ovf", 32'(ovf_err), 32'(1));
        chk("o_ackerr0", 32'(ack_err), 32'(0));
        ack = 4'b0110;
        tick();
        irq = 1'b0; ack = '0;
        chk("o_ackerr1", 32'(ack_err), 32'(1));
        chk_st("o4", 1'b1, 1'b0, 2'd0);
        tick(); chk_st("o5", 1'b1, 1'b0, 2'd0);
        tick(); chk_st("o6", 1'b0, 1'b1, 2'd0);
        tick(); chk_st("o7", 1'b1, 1'b0, 2'd1);
        chk("o7_pend", 32'(pend_valid), 32'(0));
        repeat (4) tick();
        chk_st("o11", 1'b1, 1'b0, 2'd1);
        tick(); chk_st("o12", 1'b0, 1'b1, 2'd1);
        tick(); chk_st("o13", 1'b0, 1'b0, 2'd1);

        // Invalid capture in IDLE causes no state change
        irq = 1'b1; ack = 4'b0000;
        tick();
        irq = 1'b0;
        chk_st("inv", 1'b0, 1'b0, 2'd1);

        // Reset mid-service abandons everything
        irq = 1'b1; ack = 4'b0100; svc_len = 8'd4;
        tick();
        ack = 4'b1000;
        tick();
        irq = 1'b0; ack = '0;
        chk("r_pend0", 32'(pend_valid), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_st("r", 1'b0, 1'b0, 2'd0);
        chk("r_pend", 32'(pend_valid), 32'(0));
        chk("r_ovf", 32'(ovf_err), 32'(0));
        chk("r_ackerr", 32'(ack_err), 32'(0));
        chk("r_cnt", 32'(svc_cnt), 32'(0));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_st("r_idle", 1'b0, 1'b0, 2'd0);
        end

        // Five services of source 0 saturate a 2-bit counter
        svc_len = 8'd1;
        for (int i = 0; i < 5; i++) begin
            irq = 1'b1; ack = 4'b0001;
            tick();
            irq = 1'b0; ack = '0;
            chk_st("s1", 1'b1, 1'b0, 2'd0);
            tick(); chk_st("s2", 1'b0, 1'b1, 2'd0);
            tick();
            if (i == 1)
                chk("s_cnt2", 32'(svc_cnt), CNT_ON ? 32'h02 : 32'h0);
        end
        chk("s_sat", 32'(svc_cnt), CNT_ON ? 32'h03 : 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
